// File: rtl/non_max_suppression_pkg.sv
// Shared gradient-pixel types for the edge-thinning stage.
// Provides: grad_dir_t, grad_mag_t, grad_pix_t, FSM state enum, edge-class codes
// and a magnitude classifier used when NMS_THRESHOLD_EN is defined.
package non_max_suppression_pkg;

  typedef enum logic [1:0] {
    DIR_0   = 2'd0,
    DIR_45  = 2'd1,
    DIR_90  = 2'd2,
    DIR_135 = 2'd3
  } grad_dir_t;

  typedef logic [10:0] grad_mag_t;

  typedef struct packed {
    grad_mag_t mag;
    grad_dir_t dir;
  } grad_pix_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } nms_state_t;

  localparam logic [1:0] EDGE_NONE   = 2'd0;
  localparam logic [1:0] EDGE_WEAK   = 2'd1;
  localparam logic [1:0] EDGE_STRONG = 2'd2;

  // Strong wins over weak when the thresholds overlap.
  function automatic logic [1:0] edge_classify(grad_mag_t mag, grad_mag_t lo, grad_mag_t hi);
    if (mag >= hi) return EDGE_STRONG;
    if (mag >= lo) return EDGE_WEAK;
    return EDGE_NONE;
  endfunction

endpackage

// File: rtl/nms_line_buffer.sv
// One-row delay line of gradient pixels (circular buffer, DEPTH entries).
// Ports: clk, rst (clears pointer only), en (shift), wr_dat in, rd_dat out.
// rd_dat is the entry at the pointer, i.e. the value written DEPTH shifts ago.
module nms_line_buffer
  import non_max_suppression_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  grad_pix_t wr_dat,
  output grad_pix_t rd_dat
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] ptr;
  grad_pix_t     mem [0:DEPTH-1];

  // Read-before-write at the same address gives exactly DEPTH shifts of delay.
  assign rd_dat = mem[ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

  // Contents are not reset; stale rows only ever feed border centres.
  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= wr_dat;
  end

endmodule

// File: rtl/non_max_suppression.sv
// Non-maximum suppression: thins a raster gradient stream to single-pixel edges
// using two line buffers and a 3x3 window; one output per input pixel.
// Ports: clk/rst, gradient_* input stream, nms_* output stream with x/y,
// nms_busy (end-of-frame flush), overrun_err (sticky input-during-flush).
// Optional NMS_THRESHOLD_EN adds thr_low/thr_high and the edge_class output.
module non_max_suppression
  import non_max_suppression_pkg::*;
#(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] gradient_magnitude,
  input  logic [1:0]  gradient_direction,
  input  logic        gradient_in_valid,
  output logic [10:0] nms_magnitude,
  output logic [7:0]  nms_x,
  output logic [7:0]  nms_y,
  output logic        nms_out_valid,
  output logic        nms_busy,
  output logic        overrun_err
`ifdef NMS_THRESHOLD_EN
  ,
  input  logic [10:0] thr_low,
  input  logic [10:0] thr_high,
  output logic [1:0]  edge_class
`endif
);

  localparam logic [7:0] COL_LAST   = 8'(IMG_WIDTH - 1);
  localparam logic [7:0] ROW_LAST   = 8'(IMG_HEIGHT - 1);
  localparam logic [8:0] FLUSH_LAST = 9'(IMG_WIDTH);

  nms_state_t state_q, state_d;
  logic       accept, flush_shift, advance, last_pix, center_ready;
  logic [7:0] in_col, in_row, cen_col, cen_row, win_col, win_row;
  logic [8:0] flush_cnt;
  logic       win_vld;
  grad_pix_t  new_pix, lb0_rd, lb1_rd;
  grad_pix_t  win [0:2][0:2];
  grad_mag_t  nb_a, nb_b, mag_nms;
  logic       border;

  assign last_pix = (in_col == COL_LAST) && (in_row == ROW_LAST);
  assign advance  = accept | flush_shift;
  assign nms_busy = (state_q == ST_FLUSH);

  // A centre exists once raster index >= IMG_WIDTH+1; every flush shift completes one.
  assign center_ready = flush_shift || (in_row > 8'd1) || ((in_row == 8'd1) && (in_col != 8'd0));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    flush_shift = 1'b0;
    case (state_q)
      ST_FLUSH: begin
        flush_shift = 1'b1;
        if (flush_cnt == FLUSH_LAST) state_d = ST_IDLE;
      end
      default: begin
        accept = gradient_in_valid;
        if (accept) state_d = last_pix ? ST_FLUSH : ST_RUN;
      end
    endcase
  end

  // Flush shifts push zero pixels through the window.
  always_comb begin
    new_pix = '0;
    if (accept) begin
      new_pix.mag = gradient_magnitude;
      new_pix.dir = grad_dir_t'(gradient_direction);
    end
  end

  // lb0 delays one row, lb1 a second row: rows n-2W, n-W, n enter the window.
  nms_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .clk(clk), .rst(rst), .en(advance), .wr_dat(new_pix), .rd_dat(lb0_rd)
  );

  nms_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk(clk), .rst(rst), .en(advance), .wr_dat(lb0_rd), .rd_dat(lb1_rd)
  );

  // Neighbour pair along the centre's gradient direction (row 0 = up, col 2 = right).
  always_comb begin
    nb_a = win[1][0].mag;
    nb_b = win[1][2].mag;
    case (win[1][1].dir)
      DIR_45:  begin nb_a = win[0][2].mag; nb_b = win[2][0].mag; end
      DIR_90:  begin nb_a = win[0][1].mag; nb_b = win[2][1].mag; end
      DIR_135: begin nb_a = win[0][0].mag; nb_b = win[2][2].mag; end
      default: ;
    endcase
    border  = (win_col == 8'd0) || (win_col == COL_LAST) ||
              (win_row == 8'd0) || (win_row == ROW_LAST);
    mag_nms = (!border && (win[1][1].mag >= nb_a) && (win[1][1].mag >= nb_b))
              ? win[1][1].mag : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_col        <= '0;
      in_row        <= '0;
      cen_col       <= '0;
      cen_row       <= '0;
      win_col       <= '0;
      win_row       <= '0;
      flush_cnt     <= '0;
      win_vld       <= 1'b0;
      nms_magnitude <= '0;
      nms_x         <= '0;
      nms_y         <= '0;
      nms_out_valid <= 1'b0;
      overrun_err   <= 1'b0;
`ifdef NMS_THRESHOLD_EN
      edge_class    <= EDGE_NONE;
`endif
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else begin
      win_vld <= 1'b0;
      if (advance) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb1_rd;
        win[1][2] <= lb0_rd;
        win[2][2] <= new_pix;
        if (center_ready) begin
          win_vld <= 1'b1;
          win_col <= cen_col;
          win_row <= cen_row;
          if (cen_col == COL_LAST) begin
            cen_col <= '0;
            cen_row <= (cen_row == ROW_LAST) ? 8'd0 : cen_row + 8'd1;
          end else begin
            cen_col <= cen_col + 8'd1;
          end
        end
      end
      if (accept) begin
        if (in_col == COL_LAST) begin
          in_col <= '0;
          in_row <= (in_row == ROW_LAST) ? 8'd0 : in_row + 8'd1;
        end else begin
          in_col <= in_col + 8'd1;
        end
      end
      if (flush_shift) flush_cnt <= (flush_cnt == FLUSH_LAST) ? 9'd0 : flush_cnt + 9'd1;
      if ((state_q == ST_FLUSH) && gradient_in_valid) overrun_err <= 1'b1;
      nms_out_valid <= win_vld;
      if (win_vld) begin
        nms_magnitude <= mag_nms;
        nms_x         <= win_col;
        nms_y         <= win_row;
`ifdef NMS_THRESHOLD_EN
        edge_class    <= edge_classify(mag_nms, thr_low, thr_high);
`endif
      end
    end
  end

endmodule

// File: tb/tb_non_max_suppression.sv
// Scoreboard bench for non_max_suppression at 8x6: expected outputs come from a
// coordinate-based reference model, queued when a frame is driven and popped
// as the design emits pixels.
module tb_non_max_suppression;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] gradient_magnitude;
  logic [1:0]  gradient_direction;
  logic        gradient_in_valid;
  logic [10:0] nms_magnitude;
  logic [7:0]  nms_x, nms_y;
  logic        nms_out_valid, nms_busy, overrun_err;
`ifdef NMS_THRESHOLD_EN
  logic [10:0] thr_low  = 11'd20;
  logic [10:0] thr_high = 11'd90;
  logic [1:0]  edge_class;
`endif

  always #5 clk = ~clk;

  non_max_suppression #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst),
    .gradient_magnitude(gradient_magnitude),
    .gradient_direction(gradient_direction),
    .gradient_in_valid(gradient_in_valid),
    .nms_magnitude(nms_magnitude), .nms_x(nms_x), .nms_y(nms_y),
    .nms_out_valid(nms_out_valid), .nms_busy(nms_busy), .overrun_err(overrun_err)
`ifdef NMS_THRESHOLD_EN
    , .thr_low(thr_low), .thr_high(thr_high), .edge_class(edge_class)
`endif
  );

  typedef struct {int mag; int x; int y;} exp_t;

  int   img_m [H][W];
  int   img_d [H][W];
  exp_t sb [$];
  exp_t e;
  int   n_tests = 0, n_fail = 0;
  int   out_cnt = 0, busy_cnt = 0;
  int   last_x = -1, last_y = -1, last_mag = -1;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int nms_model(int y, int x);
    int m, ay, ax, by, bx;
    if (y == 0 || y == H - 1 || x == 0 || x == W - 1) return 0;
    m = img_m[y][x];
    case (img_d[y][x])
      0:       begin ay = y;     ax = x - 1; by = y;     bx = x + 1; end
      1:       begin ay = y - 1; ax = x + 1; by = y + 1; bx = x - 1; end
      2:       begin ay = y - 1; ax = x;     by = y + 1; bx = x;     end
      default: begin ay = y - 1; ax = x - 1; by = y + 1; bx = x + 1; end
    endcase
    return (m >= img_m[ay][ax] && m >= img_m[by][bx]) ? m : 0;
  endfunction

  always @(negedge clk) begin
    if (nms_busy) busy_cnt++;
    if (nms_out_valid) begin
      out_cnt++;
      if (sb.size() == 0) begin
        check("sb_underflow", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("out_mag", int'(nms_magnitude), e.mag);
        check("out_x", int'(nms_x), e.x);
        check("out_y", int'(nms_y), e.y);
        last_x   = int'(nms_x);
        last_y   = int'(nms_y);
        last_mag = int'(nms_magnitude);
      end
    end
  end

  // Queues the whole frame's expectations, then drives the first npix pixels.
  task automatic drive_frame(input bit gaps, input int npix);
    exp_t t;
    out_cnt  = 0;
    busy_cnt = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        t.mag = nms_model(y, x);
        t.x   = x;
        t.y   = y;
        sb.push_back(t);
      end
    for (int i = 0; i < npix; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      gradient_magnitude = 11'(img_m[i / W][i % W]);
      gradient_direction = 2'(img_d[i / W][i % W]);
      gradient_in_valid  = 1'b1;
      @(posedge clk); #1;
      gradient_in_valid  = 1'b0;
    end
  endtask

  task automatic wait_frame(input string tag);
    for (int t = 0; t < 500 && out_cnt < N; t++) @(posedge clk);
    repeat (12) @(posedge clk);
    #1;
    check({tag, "_count"}, out_cnt, N);
    check({tag, "_sb_left"}, sb.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mag"}, int'(nms_magnitude), 0);
    check({tag, "_x"}, int'(nms_x), 0);
    check({tag, "_y"}, int'(nms_y), 0);
    check({tag, "_vld"}, int'(nms_out_valid), 0);
    check({tag, "_busy"}, int'(nms_busy), 0);
    check({tag, "_ovr"}, int'(overrun_err), 0);
  endtask

  initial begin
    rst = 1'b1;
    gradient_in_valid  = 1'b0;
    gradient_magnitude = '0;
    gradient_direction = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Vertical ridge, horizontal gradient: only the crest survives.
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        img_m[y][x] = (x == 3) ? 100 : ((x == 2 || x == 4) ? 50 : 0);
        img_d[y][x] = 0;
      end
    drive_frame(1'b0, N);
    wait_frame("t1");
    check("t1_busy", busy_cnt, W + 1);

    // Same ridge, vertical gradient: equal up/down neighbours are ties and kept.
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img_d[y][x] = 2;
    drive_frame(1'b0, N);
    wait_frame("t2");

    // Diagonal suppression by a stronger up-right neighbour.
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        img_m[y][x] = 0;
        img_d[y][x] = 0;
      end
    img_m[2][3] = 80;
    img_d[2][3] = 1;
    img_m[1][4] = 90;
    drive_frame(1'b0, N);
    wait_frame("t3");

    // Random small magnitudes (frequent ties), random directions, input gaps.
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        img_m[y][x] = $urandom_range(0, 15);
        img_d[y][x] = $urandom_range(0, 3);
      end
    drive_frame(1'b1, N);
    wait_frame("t4");
    check("t4_busy", busy_cnt, W + 1);
    check("t4_last_x", last_x, W - 1);
    check("t4_last_y", last_y, H - 1);
    check("t4_last_mag", last_mag, 0);

    // Input arriving in the third flush cycle is dropped and flagged.
    drive_frame(1'b0, N);
    @(posedge clk); #1;
    @(posedge clk); #1;
    gradient_magnitude = 11'd7;
    gradient_in_valid  = 1'b1;
    @(posedge clk); #1;
    gradient_in_valid  = 1'b0;
    wait_frame("t5");
    check("t5_overrun", int'(overrun_err), 1);
    repeat (20) @(posedge clk);
    #1;
    check("t5_overrun_sticky", int'(overrun_err), 1);
    check("t5_count_after", out_cnt, N);

    // Reset mid-frame abandons it; a fresh frame then runs cleanly.
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        img_m[y][x] = $urandom_range(0, 31);
        img_d[y][x] = $urandom_range(0, 3);
      end
    drive_frame(1'b0, 21);
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    out_cnt = 0;
    @(negedge clk);
    check_all_zero("t6_rst");
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t6_no_output", out_cnt, 0);
    drive_frame(1'b1, N);
    wait_frame("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
